// File: rtl/dmem_wait_responder.sv
// Word-organised data RAM behind a valid/ready request/response handshake
// with a fixed number of wait states; one transaction outstanding at a time.
module dmem_wait_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [3:0]  req_be_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WORD_W   = 30;
  localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
  localparam bit          ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic               rsp_valid_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic [31:0]        mem_q [DEPTH_WORDS];

  logic               accept_c;
  logic               commit_c;
  logic               c_we;
  logic [31:0]        c_addr;
  logic [31:0]        c_wdata;
  logic [3:0]         c_be;
  logic [WORD_W-1:0]  c_word;
  logic [IDX_W-1:0]   c_idx;
  logic               c_err;

  assign req_ready_o = (state_q == IDLE) && !reset_i;
  assign accept_c    = req_valid_i && req_ready_o;

  // With zero latency the commit happens on the accept edge, so take the live request.
  assign c_we    = (state_q == IDLE) ? req_we_i    : we_q;
  assign c_addr  = (state_q == IDLE) ? req_addr_i  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata_i : wdata_q;
  assign c_be    = (state_q == IDLE) ? req_be_i    : be_q;

  assign c_word = WORD_W'((c_addr - BASE_ADDR) >> 2);
  assign c_idx  = c_word[IDX_W-1:0];
  assign c_err  = (c_addr[1:0] != 2'b00) || (c_word >= WORD_W'(DEPTH_WORDS));

  assign commit_c = !reset_i && (ZERO_LAT ? accept_c
                                          : ((state_q == BUSY) && (cnt_q == '0)));

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (commit_c && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem_q[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

  // Transaction FSM with registered response outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            we_q    <= req_we_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            if (ZERO_LAT) begin
              state_q <= RESP;
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        BUSY: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (commit_c) begin
        rsp_valid_q <= 1'b1;
        rdata_q     <= (c_we || c_err) ? 32'h0 : mem_q[c_idx];
        err_q       <= c_err;
      end
    end
  end

endmodule
